axi4_burst_ram_slave: RTL and testbench
=======================================

AXI4_BURST_RAM_SLAVE -- requirements
Module: axi4_burst_ram_slave

Interface
REQ-001 SHALL have parameter ID_W, default 4: AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-003 SHALL have parameter DATA_W, default 256: data width, power of two, at least 32.
REQ-004 SHALL have parameter DEPTH, default 64: number of DATA_W words, power of two.
REQ-005 SHALL have port clk, input, 1 bit: clock for all logic.
REQ-006 SHALL have port m00_axi_aresetn, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have AW-channel inputs s_axi_awid/awaddr/awlen/awsize/awburst/awvalid (ID_W/ADDR_W/8/3/2/1 bits) and output s_axi_awready (1 bit).
REQ-008 SHALL have W-channel inputs s_axi_wdata/wstrb/wlast/wvalid (DATA_W/DATA_W/8/1/1 bits) and output s_axi_wready (1 bit).
REQ-009 SHALL have B-channel outputs s_axi_bid/bresp/bvalid (ID_W/2/1 bits) and input s_axi_bready (1 bit).
REQ-010 SHALL have AR-channel inputs s_axi_arid/araddr/arlen/arsize/arburst/arvalid (ID_W/ADDR_W/8/3/2/1 bits) and output s_axi_arready (1 bit).
REQ-011 SHALL have R-channel outputs s_axi_rid/rdata/rresp/rlast/rvalid (ID_W/DATA_W/2/1/1 bits) and input s_axi_rready (1 bit).

Function
REQ-012 SHALL map each address to a word index as addr[LSB +: log2(DEPTH)], where LSB = log2(DATA_W/8); upper address bits are ignored, so addresses wrap modulo DEPTH.
REQ-013 SHALL run the write FSM as W_IDLE (awready=1) -> W_DATA on AW handshake (latch id/addr/len/burst, set error flag) -> W_RESP on a W handshake with wlast=1 -> W_IDLE on B handshake.
REQ-014 SHALL assert wready only in W_DATA and bvalid only in W_RESP; bvalid SHALL hold with bid, bresp stable until bready=1.
REQ-015 SHALL write each W beat into the array per byte lane, enabled by wstrb, one beat per cycle; with wvalid held high it SHALL accept awlen+1 beats in awlen+1 consecutive cycles.
REQ-016 SHALL increment the word index by 1 after each beat for awburst=INCR (01) and hold it constant for FIXED (00); the index SHALL wrap from DEPTH-1 to 0.
REQ-017 SHALL drive bresp=SLVERR (10), without writing the array, when awburst=WRAP/reserved or awsize != LSB; otherwise bresp=OKAY (00).
REQ-018 SHALL still write the data but return SLVERR when wlast arrives at a beat count other than awlen+1; it SHALL leave W_DATA only on wlast.
REQ-019 SHALL run the read FSM as R_IDLE (arready=1) -> R_DATA on AR handshake -> R_IDLE on R handshake with rlast=1.
REQ-020 SHALL provide a registered array read: first rvalid exactly 1 cycle after the AR handshake, then one beat per cycle while rready=1 (no bubbles); rdata/rlast SHALL hold while rvalid=1 and rready=0.
REQ-021 SHALL assert rlast on beat arlen+1, drive rid=latched arid, and use the same burst/size rules as REQ-016/017 with rresp=SLVERR and rdata=0 on error, still returning arlen+1 beats.
REQ-022 SHALL run the read and write FSMs fully independently, with one outstanding burst each; a same-cycle read and write of one word SHALL return the old data (read-first).
REQ-023 SHALL support awlen/arlen 0..255; len=0 SHALL produce a single beat with wlast/rlast on it.

Reset
REQ-024 SHALL, while m00_axi_aresetn=1, force both FSMs to IDLE and drive all ready/valid outputs to 0 and all id/resp/last/data outputs to 0; awready and arready SHALL rise in the first cycle after release.
REQ-025 SHALL abandon any burst in progress on reset mid-operation without a B or R response; array contents SHALL NOT be reset.

Structure
REQ-026 SHALL place the burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR) and FSM state enums in package axi4_pkg, shared with the master.
REQ-027 SHALL implement the storage as one sub-module axi4_ram_dp: simple dual-port, byte-enable write, registered read-first read.

Verification
REQ-028 SHALL cover: write INCR awaddr=0x0, awlen=7, data 1..8, wstrb all-ones -> 8 beats, one per cycle, then bresp=00 and bid=awid.
REQ-029 SHALL cover: read araddr=0x0, arlen=7 after REQ-028 -> rvalid 1 cycle after AR, rdata 1..8, rlast on beat 8 only.
REQ-030 SHALL cover: write awaddr=(DEPTH-2)*32, awlen=3 -> words DEPTH-2, DEPTH-1, 0, 1 written, confirmed by read-back.
REQ-031 SHALL cover: awburst=10 or awsize=3 with DATA_W=256 -> bresp=10 and the array unchanged; arburst=10 -> arlen+1 beats with rresp=10 and rdata=0.
REQ-032 SHALL cover: rready toggling every other cycle during an 8-beat read -> no lost or duplicated beats, and rdata stable while stalled.
REQ-033 SHALL cover: assertion of m00_axi_aresetn mid-burst -> all valids 0 at once, a new write after release completes with OKAY, and earlier memory contents are retained.

Source files
------------

// File: rtl/axi4_pkg.sv
// ============================================================================
// Module      : axi4_pkg
// Description : Shared AXI4 encodings and FSM state types for master/slave.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package axi4_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Only FIXED and INCR are served; WRAP and the reserved code are errors.
    function automatic logic burst_supported(input logic [1:0] burst);
        case (burst)
            c_BURST_FIXED, c_BURST_INCR: return 1'b1;
            c_BURST_WRAP:                return 1'b0;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_ram_dp.sv
// ============================================================================
// Module      : axi4_ram_dp
// Description : Simple dual-port RAM, byte-enable write, registered read-first read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi4_ram_dp #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_re,
    input  logic [IDX_W-1:0]    i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int c_NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately never reset so data survives a bus reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_NB; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/axi4_burst_ram_slave.sv
// ============================================================================
// Module      : axi4_burst_ram_slave
// Description : AXI4 burst slave (FIXED/INCR) in front of a dual-port word RAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi4_burst_ram_slave
    import axi4_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                m00_axi_aresetn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int               c_LSB     = $clog2(DATA_W / 8);
    localparam int               c_IDX_W   = $clog2(DEPTH);
    localparam logic [2:0]       c_SIZE    = 3'(c_LSB);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = 1;

    // ---------------- write channel ----------------
    wr_state_t            r_wstate, w_wstate_nxt;
    logic [ID_W-1:0]      r_wid;
    logic [c_IDX_W-1:0]   r_widx;
    logic [7:0]           r_wlen, r_wcnt;
    logic [1:0]           r_wburst;
    logic                 r_wcfg_err, r_wlen_err;
    logic                 w_awready, w_wready, w_bvalid;
    logic                 w_aw_hs, w_w_hs;

    always_ff @(posedge clk or posedge m00_axi_aresetn) begin
        if (m00_axi_aresetn) r_wstate <= W_IDLE;
        else                 r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (s_axi_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;

    always_ff @(posedge clk or posedge m00_axi_aresetn) begin
        if (m00_axi_aresetn) begin
            r_wid      <= '0;
            r_widx     <= '0;
            r_wlen     <= '0;
            r_wcnt     <= '0;
            r_wburst   <= '0;
            r_wcfg_err <= 1'b0;
            r_wlen_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid      <= s_axi_awid;
            r_widx     <= s_axi_awaddr[c_LSB +: c_IDX_W];
            r_wlen     <= s_axi_awlen;
            r_wcnt     <= '0;
            r_wburst   <= s_axi_awburst;
            r_wcfg_err <= !burst_supported(s_axi_awburst) || (s_axi_awsize != c_SIZE);
            r_wlen_err <= 1'b0;
        end else if (w_w_hs) begin
            r_wcnt <= r_wcnt + 8'd1;
            if (r_wburst == c_BURST_INCR) r_widx <= r_widx + c_IDX_ONE;
            // wlast must coincide exactly with beat awlen+1; sticky once violated.
            if (s_axi_wlast != (r_wcnt == r_wlen)) r_wlen_err <= 1'b1;
        end
    end

    assign s_axi_awready = w_awready & ~m00_axi_aresetn;
    assign s_axi_wready  = w_wready;
    assign s_axi_bvalid  = w_bvalid;
    assign s_axi_bid     = r_wid;
    assign s_axi_bresp   = (w_bvalid && (r_wcfg_err || r_wlen_err)) ? c_RESP_SLVERR : c_RESP_OKAY;

    // ---------------- read channel ----------------
    rd_state_t            r_rstate, w_rstate_nxt;
    logic [ID_W-1:0]      r_rid;
    logic [c_IDX_W-1:0]   r_ridx;
    logic [7:0]           r_rlen, r_rcnt;
    logic [1:0]           r_rburst;
    logic                 r_rerr;
    logic                 w_arready, w_rvalid, w_rlast;
    logic                 w_ar_hs, w_r_hs, w_ram_re;
    logic [c_IDX_W-1:0]   w_ar_idx, w_ridx_next, w_ram_raddr;
    logic [DATA_W-1:0]    w_ram_q;

    always_ff @(posedge clk or posedge m00_axi_aresetn) begin
        if (m00_axi_aresetn) r_rstate <= R_IDLE;
        else                 r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (s_axi_arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (s_axi_rready && w_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_rlast     = (r_rstate == R_DATA) && (r_rcnt == r_rlen);
    assign w_ar_hs     = s_axi_arvalid & s_axi_arready;
    assign w_r_hs      = w_rvalid & s_axi_rready;
    assign w_ar_idx    = s_axi_araddr[c_LSB +: c_IDX_W];
    assign w_ridx_next = (r_rburst == c_BURST_INCR) ? r_ridx + c_IDX_ONE : r_ridx;

    // The RAM output register is the R data register: it only advances on
    // AR acceptance or a non-final beat handshake, so it holds while stalled.
    assign w_ram_re    = w_ar_hs | (w_r_hs & ~w_rlast);
    assign w_ram_raddr = w_ar_hs ? w_ar_idx : w_ridx_next;

    always_ff @(posedge clk or posedge m00_axi_aresetn) begin
        if (m00_axi_aresetn) begin
            r_rid    <= '0;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rburst <= '0;
            r_rerr   <= 1'b0;
        end else if (w_ar_hs) begin
            r_rid    <= s_axi_arid;
            r_ridx   <= w_ar_idx;
            r_rlen   <= s_axi_arlen;
            r_rcnt   <= '0;
            r_rburst <= s_axi_arburst;
            r_rerr   <= !burst_supported(s_axi_arburst) || (s_axi_arsize != c_SIZE);
        end else if (w_r_hs && !w_rlast) begin
            r_ridx <= w_ridx_next;
            r_rcnt <= r_rcnt + 8'd1;
        end
    end

    assign s_axi_arready = w_arready & ~m00_axi_aresetn;
    assign s_axi_rvalid  = w_rvalid;
    assign s_axi_rlast   = w_rlast;
    assign s_axi_rid     = r_rid;
    assign s_axi_rresp   = (w_rvalid && r_rerr) ? c_RESP_SLVERR : c_RESP_OKAY;
    assign s_axi_rdata   = (w_rvalid && !r_rerr) ? w_ram_q : '0;

    axi4_ram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_w_hs & ~r_wcfg_err),
        .i_waddr (r_widx),
        .i_wdata (s_axi_wdata),
        .i_wstrb (s_axi_wstrb),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    logic w_unused;
    assign w_unused = ^{s_axi_awaddr, s_axi_araddr};

endmodule

`default_nettype wire

// File: tb/tb_axi4_burst_ram_slave.sv
// ============================================================================
// Module      : tb_axi4_burst_ram_slave
// Description : Directed bench with a word-array model and per-cycle R/B checker.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_axi4_burst_ram_slave;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 64;
    localparam int NB     = DATA_W / 8;

    logic                clk = 1'b0;
    logic                m00_axi_aresetn = 1'b1;
    logic [ID_W-1:0]     awid = '0, arid = '0;
    logic [ADDR_W-1:0]   awaddr = '0, araddr = '0;
    logic [7:0]          awlen = '0, arlen = '0;
    logic [2:0]          awsize = 3'd5, arsize = 3'd5;
    logic [1:0]          awburst = 2'b01, arburst = 2'b01;
    logic                awvalid = 1'b0, arvalid = 1'b0;
    logic [DATA_W-1:0]   wdata = '0;
    logic [NB-1:0]       wstrb = '0;
    logic                wlast = 1'b0, wvalid = 1'b0;
    logic                bready = 1'b1, rready = 1'b1;
    logic                awready, wready, bvalid, arready, rlast, rvalid;
    logic [ID_W-1:0]     bid, rid;
    logic [1:0]          bresp, rresp;
    logic [DATA_W-1:0]   rdata;

    always #5 clk = ~clk;

    axi4_burst_ram_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .m00_axi_aresetn(m00_axi_aresetn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] m_mem [DEPTH];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [1:0]        resp;
        logic [ID_W-1:0]   id;
    } rbeat_t;

    typedef struct {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } bexp_t;

    rbeat_t            exp_r[$];
    bexp_t             exp_b[$];
    logic [DATA_W-1:0] cap[$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [ADDR_W-1:0] addr, input logic [1:0] burst, input int beat);
        return int'((addr / NB + ((burst == 2'b01) ? beat : 0)) % DEPTH);
    endfunction

    // Per-cycle checker: whatever the slave presents on R or B must equal the
    // head of the expectation queue; the head is retired only on a handshake.
    always @(negedge clk) begin
        if (!m00_axi_aresetn) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected_beat", 1, 0);
                end else begin
                    chk("rdata", rdata, exp_r[0].data);
                    chk("rlast", rlast, exp_r[0].last);
                    chk("rresp", rresp, exp_r[0].resp);
                    chk("rid",   rid,   exp_r[0].id);
                    if (rready) begin
                        cap.push_back(rdata);
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                end else begin
                    chk("bresp", bresp, exp_b[0].resp);
                    chk("bid",   bid,   exp_b[0].id);
                    if (bready) void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int nbeats, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] base, input logic [NB-1:0] strb, input bit bdelay);
        bit cfg_err;
        int t;
        int idx;
        cfg_err = !((burst == 2'b00) || (burst == 2'b01)) || (size != 3'd5);
        if (bdelay) bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awid = id;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 50);
        if (!awready) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = base + DATA_W'(i); wstrb = strb; wlast = (i == nbeats - 1);
            @(negedge clk);
            chk("wready_beat", wready, 1);
            if (!cfg_err) begin
                idx = word_of(addr, burst, i);
                for (int b = 0; b < NB; b++)
                    if (strb[b]) m_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_b.push_back('{resp: (cfg_err || nbeats != len + 1) ? 2'b10 : 2'b00, id: id});
        if (bdelay) begin
            repeat (3) @(posedge clk);
            #1 bready = 1'b1;
        end
        t = 0;
        while (exp_b.size() > 0 && t < 50) begin @(posedge clk); #1; t++; end
        if (exp_b.size() > 0) begin
            chk("b_timeout", 0, 1);
            exp_b.delete();
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] burst,
                           input logic [ID_W-1:0] id, input bit toggle);
        bit err;
        int t;
        err = !((burst == 2'b00) || (burst == 2'b01));
        for (int i = 0; i <= len; i++)
            exp_r.push_back('{data: err ? '0 : m_mem[word_of(addr, burst, i)],
                              last: (i == len), resp: err ? 2'b10 : 2'b00, id: id});
        cap.delete();
        rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arburst = burst; arsize = 3'd5; arid = id;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        if (!arready) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("r_first_latency", rvalid, 1);
        t = 0;
        while (exp_r.size() > 0 && t < 600) begin
            @(posedge clk); #1;
            if (toggle) rready = ~rready;
            t++;
        end
        if (exp_r.size() > 0) begin
            chk("r_timeout", 0, 1);
            exp_r.delete();
        end
        rready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready",  wready,  0);
        chk("rst_bvalid",  bvalid,  0);
        chk("rst_rvalid",  rvalid,  0);
        chk("rst_rdata",   rdata,   0);
        chk("rst_rlast",   rlast,   0);
        chk("rst_bid",     bid,     0);
        @(posedge clk); #1 m00_axi_aresetn = 1'b0;
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        // INCR write of 1..8 then read-back
        do_write(32'h0, 7, 2'b01, 3'd5, 8, 4'd3, 256'd1, '1, 1'b0);
        do_read(32'h0, 7, 2'b01, 4'd5, 1'b0);
        chk("t1_count", 32'(cap.size()), 8);
        for (int k = 0; k < 8 && k < cap.size(); k++) chk("t1_literal", cap[k], 256'(k + 1));

        // INCR burst wrapping around the top of the array
        do_write(32'((DEPTH - 2) * 32), 3, 2'b01, 3'd5, 4, 4'd1, 256'h100, '1, 1'b0);
        do_read(32'((DEPTH - 2) * 32), 3, 2'b01, 4'd1, 1'b0);
        for (int k = 0; k < 4 && k < cap.size(); k++) chk("wrap_literal", cap[k], 256'h100 + 256'(k));
        do_read(32'h0, 7, 2'b01, 4'd2, 1'b0);
        if (cap.size() > 2) begin
            chk("wrap_word0", cap[0], 256'h102);
            chk("wrap_word2", cap[2], 256'd3);
        end

        // configuration errors: nothing written, SLVERR, B held while stalled
        do_write(32'd2 * 32, 1, 2'b10, 3'd5, 2, 4'd7, 256'hDEAD, '1, 1'b1);
        do_write(32'd2 * 32, 1, 2'b01, 3'd3, 2, 4'd6, 256'hBEEF, '1, 1'b0);
        do_read(32'd2 * 32, 1, 2'b01, 4'd4, 1'b0);
        if (cap.size() > 1) begin
            chk("err_unchanged0", cap[0], 256'd3);
            chk("err_unchanged1", cap[1], 256'd4);
        end
        do_read(32'h0, 3, 2'b10, 4'd9, 1'b0);
        do_read(32'h0, 0, 2'b11, 4'd8, 1'b0);

        // wlast early / late: data written, SLVERR
        do_write(32'd10 * 32, 3, 2'b01, 3'd5, 2, 4'd2, 256'h700, '1, 1'b0);
        do_write(32'd20 * 32, 1, 2'b01, 3'd5, 3, 4'd2, 256'h800, '1, 1'b0);
        do_read(32'd10 * 32, 1, 2'b01, 4'd2, 1'b0);
        do_read(32'd20 * 32, 2, 2'b01, 4'd2, 1'b0);
        if (cap.size() > 2) chk("late_wlast_word22", cap[2], 256'h802);

        // FIXED burst with partial strobes, single-beat bursts
        do_write(32'd30 * 32, 0, 2'b01, 3'd5, 1, 4'd0, '1, '1, 1'b0);
        do_write(32'd30 * 32, 3, 2'b00, 3'd5, 4, 4'd15, 256'hAB00, 32'h3, 1'b0);
        do_read(32'd30 * 32, 0, 2'b01, 4'd15, 1'b0);
        if (cap.size() > 0) chk("fixed_literal", cap[0], {{(DATA_W-16){1'b1}}, 16'hAB03});

        // rready toggling every other cycle
        do_read(32'h0, 7, 2'b01, 4'd11, 1'b1);
        chk("toggle_count", 32'(cap.size()), 8);

        // reset in the middle of a write burst
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = 32'd40 * 32; awlen = 8'd7; awburst = 2'b01; awsize = 3'd5; awid = 4'd2;
        @(negedge clk);
        chk("mid_awready", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = 256'h500 + 256'(i); wstrb = '1; wlast = 1'b0;
            @(negedge clk);
            chk("mid_wready", wready, 1);
            m_mem[40 + i] = wdata;
            @(posedge clk); #1;
        end
        m00_axi_aresetn = 1'b1;
        wvalid = 1'b0;
        #1;
        chk("mid_rst_wready",  wready,  0);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_bvalid",  bvalid,  0);
        chk("mid_rst_rvalid",  rvalid,  0);
        chk("mid_rst_arready", arready, 0);
        repeat (2) @(posedge clk);
        #1 m00_axi_aresetn = 1'b0;
        @(negedge clk);
        chk("mid_rel_awready", awready, 1);
        chk("mid_rel_wready",  wready,  0);
        do_write(32'd50 * 32, 1, 2'b01, 3'd5, 2, 4'd4, 256'h900, '1, 1'b0);
        do_read(32'd40 * 32, 2, 2'b01, 4'd3, 1'b0);
        for (int k = 0; k < 3 && k < cap.size(); k++) chk("mid_retained", cap[k], 256'h500 + 256'(k));
        do_read(32'h0, 7, 2'b01, 4'd3, 1'b0);
        do_read(32'd50 * 32, 1, 2'b01, 4'd3, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
